// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIBBLE_W : width of one slice handled by the 4-bit full_adder per cycle.
//   state_t  : sequencer states (IDLE accepts, RUN adds one nibble per cycle,
//              DONE presents the result until the consumer takes it).
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : nibble_adder_pkg

// File: rtl/nibble_serial_adder_if.sv
// Operand / result handshake bundle for nibble_serial_adder.
//   in_valid/in_ready   : operand request; a, b, c_in qualified by in_valid.
//   out_valid/out_ready : result handshake; sum, c_out qualified by out_valid.
//   busy                : adder is in RUN or DONE.
// master: the producer/consumer side; slave: the adder itself.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, busy
  );

endinterface : nibble_serial_adder_if

// File: rtl/full_adder.sv
// Existing 4-bit combinational adder reused by nibble_serial_adder.
//   a, b  : 4-bit addends
//   c_in  : carry in
//   sum   : 4-bit sum
//   c_out : carry out of bit 3
module full_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};

endmodule : full_adder

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder built around a single 4-bit full_adder.
// Operands are latched on acceptance, then one nibble per clock is added,
// LSB nibble first, with the carry chained through a register. The wide sum
// is presented over a valid/ready handshake and held until the next accept.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nibble_serial_adder_if (operands in, result out,
//           busy high in RUN or DONE)
import nibble_adder_pkg::*;

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;

  logic [NIBBLE_W-1:0] fa_sum;
  logic                fa_c_out;

  full_adder u_full_adder (
    .a     (a_reg[idx*NIBBLE_W +: NIBBLE_W]),
    .b     (b_reg[idx*NIBBLE_W +: NIBBLE_W]),
    .c_in  (carry),
    .sum   (fa_sum),
    .c_out (fa_c_out)
  );

  // NOTE: every register here is sequential state, so it is written with
  // non-blocking assignments; blocking ones would let later statements in the
  // same edge see the new value and break the carry/sum ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      // NOTE: the operand copies are reset too, even though they are always
      // reloaded before use, so no X can reach the adder after an abort.
      a_reg   <= '0;
      b_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            carry <= bus.c_in;
            idx   <= '0;
            sum_q <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[idx*NIBBLE_W +: NIBBLE_W] <= fa_sum;
          carry                           <= fa_c_out;
          if (idx == LAST_IDX) begin
            c_out_q <= fa_c_out;
            state   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Result stays frozen here and afterwards in IDLE until a new accept.
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags depend on the state register only, never on in_valid or
  // out_ready, so there is no combinational path through the block.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16).
// Expected results come from plain a+b+c_in arithmetic; latency and
// handshake timing expectations come from the cycle rules of the block.
module tb_nibble_serial_adder;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;
  localparam int TIMEOUT = 50;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the full (WIDTH+1)-bit sum of the operands.
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] av,
                                             input logic [WIDTH-1:0] bv,
                                             input logic cv);
    return {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
  endfunction

  // Presents one operand set, waits for out_valid (bounded) and returns the
  // number of edges from the accept edge to out_valid plus the result seen.
  // Inputs are scrambled after acceptance to show the latched copy is used.
  task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic cv, output int lat,
                       output logic [WIDTH-1:0] s, output logic c);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    bus.c_in     = cv;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = WIDTH'($urandom);
    bus.b        = WIDTH'($urandom);
    bus.c_in     = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    s = bus.sum;
    c = bus.c_out;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.c_out} !== 4'b1000 ||
        bus.sum !== 16'h0000) begin
      errors++;
      $display("FAIL reset: in_ready/out_valid/busy/c_out=%b sum=%h, want 1000 sum=0000",
               {bus.in_ready, bus.out_valid, bus.busy, bus.c_out}, bus.sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic directed(input string name, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic cv,
                          input logic [WIDTH-1:0] exp_s, input logic exp_c);
    int               lat;
    logic [WIDTH-1:0] s;
    logic             c;
    bus.out_ready = 1'b1;
    do_op(av, bv, cv, lat, s, c);
    checks++;
    if (lat !== NIBBLES) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, want %0d", name, lat, NIBBLES);
    end
    checks++;
    if ({c, s} !== {exp_c, exp_s} || {c, s} !== ref_add(av, bv, cv)) begin
      errors++;
      $display("FAIL %s result: got c_out=%b sum=%h, want c_out=%b sum=%h",
               name, c, s, exp_c, exp_s);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== exp_s) begin
      errors++;
      $display("FAIL %s one-cycle valid: out_valid=%b in_ready=%b sum=%h, want 0 1 %h",
               name, bus.out_valid, bus.in_ready, bus.sum, exp_s);
    end
  endtask

  task automatic test_basic();
    directed("small_add", 16'h0002, 16'h0004, 1'b0, 16'h0006, 1'b0);
    directed("full_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    directed("cin_ripple", 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0);
  endtask

  task automatic test_hold_off();
    int               lat;
    logic [WIDTH-1:0] s;
    logic             c;
    bus.out_ready = 1'b0;
    do_op(16'hBEEF, 16'hB00E, 1'b1, lat, s, c);
    checks++;
    if (lat !== NIBBLES || s !== 16'h6EFE || c !== 1'b1) begin
      errors++;
      $display("FAIL hold_off first: lat=%0d c_out=%b sum=%h, want %0d 1 6efe",
               lat, c, s, NIBBLES);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 16'h1111;
      bus.b        = 16'h1111;
      bus.c_in     = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.sum !== 16'h6EFE || bus.c_out !== 1'b1) begin
        errors++;
        $display("FAIL hold_off cycle %0d: out_valid=%b in_ready=%b c_out=%b sum=%h, want 1 0 1 6efe",
                 i, bus.out_valid, bus.in_ready, bus.c_out, bus.sum);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_off release: out_valid=%b in_ready=%b busy=%b, want 0 1 0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.sum !== 16'h6EFE || bus.c_out !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_off sticky: c_out=%b sum=%h busy=%b, want 1 6efe 0",
               bus.c_out, bus.sum, bus.busy);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h1234;
    bus.b         = 16'h1111;
    bus.c_in      = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.sum !== 16'h0000 || bus.c_out !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: sum=%h c_out=%b out_valid=%b in_ready=%b busy=%b, want 0000 0 0 1 0",
               bus.sum, bus.c_out, bus.out_valid, bus.in_ready, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    directed("after_reset", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 16'h0002;
    bus.b        = 16'h0004;
    bus.c_in     = 1'b0;
    @(posedge clk);
    #1;
    bus.a = 16'h8000;
    bus.b = 16'h8000;
    repeat (NIBBLES) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0006 || bus.c_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b first: out_valid=%b c_out=%b sum=%h, want 1 0 0006",
               bus.out_valid, bus.c_out, bus.sum);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle edge: in_ready=%b busy=%b, want 1 0",
               bus.in_ready, bus.busy);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b second accept: in_ready=%b busy=%b, want 0 1",
               bus.in_ready, bus.busy);
    end
    lat = 0;
    while (!bus.out_valid && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== NIBBLES || bus.sum !== 16'h0000 || bus.c_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b second: lat=%0d c_out=%b sum=%h, want %0d 1 0000",
               lat, bus.c_out, bus.sum, NIBBLES);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int               lat;
    int               delay;
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] bv;
    logic             cv;
    logic [WIDTH-1:0] s;
    logic             c;
    logic [WIDTH:0]   expv;
    for (int n = 0; n < 40; n++) begin
      av    = WIDTH'($urandom);
      bv    = WIDTH'($urandom);
      cv    = 1'($urandom);
      delay = $urandom_range(0, 3);
      expv  = ref_add(av, bv, cv);
      bus.out_ready = (delay == 0);
      do_op(av, bv, cv, lat, s, c);
      checks++;
      if (lat !== NIBBLES || {c, s} !== expv) begin
        errors++;
        $display("FAIL random %0d: a=%h b=%h c_in=%b lat=%0d got %b_%h, want %0d %b_%h",
                 n, av, bv, cv, lat, c, s, NIBBLES, expv[WIDTH], expv[WIDTH-1:0]);
      end
      if (delay != 0) begin
        repeat (delay) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.c_out, bus.sum} !== expv) begin
          errors++;
          $display("FAIL random %0d hold: out_valid=%b got %b_%h, want 1 %b_%h",
                   n, bus.out_valid, bus.c_out, bus.sum, expv[WIDTH], expv[WIDTH-1:0]);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL random %0d return: out_valid=%b in_ready=%b, want 0 1",
                 n, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_hold_off();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_nibble_serial_adder

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder that sits directly upstream of the existing 4-bit full_adder and drives it.
- Accepts wide operands over a valid/ready handshake and feeds the full_adder one 4-bit nibble per clock, LSB nibble first.
- Chains the carry through a register and assembles the wide sum.
- Delivers the result over a valid/ready handshake; trades latency for reuse of the single 4-bit adder.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4 (elaboration-time assertion).
- NIBBLES, WIDTH/4, derived localparam: number of RUN cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in to nibble 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered result.
- c_out  output  1  carry out of the top nibble.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous assert, rst_n=0):
  - state=IDLE; index, carry, sum, c_out and operand registers all 0.
  - in_ready=1, out_valid=0, busy=0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge: latch a and b, set carry<=c_in, idx<=0, sum<=0, go to RUN.
- RUN (in_ready=0):
  - Each cycle, full_adder inputs are a_reg[idx*4+:4], b_reg[idx*4+:4] and carry.
  - At each edge: sum[idx*4+:4]<=fa_sum; carry<=fa_c_out.
  - If idx==NIBBLES-1: c_out<=fa_c_out and go to DONE; otherwise idx<=idx+1.
- DONE:
  - out_valid=1; sum and c_out held stable.
  - On out_ready at an edge: go to IDLE.
- Latency: out_valid rises exactly NIBBLES cycles after the accepting edge (4 cycles for WIDTH=16).
- Throughput: one operation per NIBBLES+2 cycles minimum.
- in_ready is high only in IDLE; in_valid in RUN or DONE is ignored and no operands are latched.
- Arithmetic:
  - {c_out,sum} equals a+b+c_in exactly, modulo 2^(WIDTH+1).
  - Wrap-around is reported only through c_out, with no saturation.
- sum and c_out stay unchanged from DONE until the next accept, so a late consumer still sees the last result.
- in_ready and out_valid are decoded from state only, with no combinational path from in_valid or out_ready.
- Reset mid-operation (RUN or DONE): the operation is aborted, the result is discarded, and all outputs return to their reset values immediately (asynchronous).
- Operands changing on the a/b/c_in inputs during RUN have no effect, because the latched copies are used.

Decomposition:
- Package nibble_adder_pkg holds:
  - NIBBLE_W=4;
  - the state enum type (IDLE, RUN, DONE) as 2-bit logic.
- One sub-module: the existing full_adder, instantiated once (ports a, b, c_in, sum, c_out, 4-bit).
- The FSM, index counter, carry register and sum assembly stay in nibble_serial_adder.

Test Plan (WIDTH=16):
1. a=0x0002, b=0x0004, c_in=0, out_ready=1:
   - sum=0x0006, c_out=0;
   - out_valid high exactly 4 cycles after the accept edge, for 1 cycle.
2. a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1 (carry ripples through all four nibbles).
3. a=0x0FFF, b=0x0000, c_in=1 -> sum=0x1000, c_out=0.
4. a=0xBEEF, b=0xB00E, c_in=1 with out_ready held low 5 cycles, and a new in_valid (a=0x1111) applied during DONE:
   - sum=0x6EFE and c_out=1, held stable;
   - in_ready=0 throughout and the new request is ignored;
   - return to IDLE one edge after out_ready rises.
5. Start a=0x1234, b=0x1111, then pull rst_n low after 2 RUN cycles:
   - sum=0, c_out=0, out_valid=0, in_ready=1 immediately;
   - after release, a=0x0001, b=0x0001 -> sum=0x0002.
6. Back-to-back pair with in_valid held high:
   - first result 0x0002+0x0004 -> 0x0006;
   - second op 0x8000+0x8000 c_in=0 -> sum=0x0000, c_out=1;
   - second accept occurs the edge after the DONE->IDLE transition.
